// File: rtl/tag_decoder.sv
// Rebuilds window framing (sof/eof, completed-window count, sticky errors)
// from a sample stream whose first sample per window carries a one-cycle tag.
module tag_decoder #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 16,
   parameter int CNT_W  = 32
) (
   input  logic              clock,
   input  logic              reset_int,
   input  logic              enable,
   input  logic [LEN_W-1:0]  win_len,
   input  logic              in_valid,
   input  logic              in_tag,
   input  logic [DATA_W-1:0] in_data,
   input  logic              err_clr,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sof,
   output logic              out_eof,
   output logic [CNT_W-1:0]  win_cnt,
   output logic              err_short,
   output logic              err_long,
   output logic              busy
);

   typedef enum logic [1:0] {HUNT = 2'd0, WIN = 2'd1, GAP = 2'd2} state_t;

   state_t              state, state_n;
   logic [LEN_W-1:0]    cnt, cnt_n, cnt_inc;
   logic [LEN_W-1:0]    len_r, len_n, tag_len;
   logic [CNT_W-1:0]    win_cnt_n;
   logic                valid_n, sof_n, eof_n;
   logic [DATA_W-1:0]   data_n;
   logic                set_short, set_long;

   assign cnt_inc = cnt + 1'b1;
   // A zero length would never complete, so it is promoted to one sample.
   assign tag_len = (win_len == '0) ? LEN_W'(1) : win_len;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      len_n     = len_r;
      win_cnt_n = win_cnt;
      valid_n   = 1'b0;
      data_n    = out_data;
      sof_n     = 1'b0;
      eof_n     = 1'b0;
      set_short = 1'b0;
      set_long  = 1'b0;
      if (!enable) begin
         state_n = HUNT;
         cnt_n   = '0;
      end else if (in_valid) begin
         if (in_tag) begin
            set_short = (state == WIN);
            valid_n   = 1'b1;
            data_n    = in_data;
            sof_n     = 1'b1;
            len_n     = tag_len;
            cnt_n     = LEN_W'(1);
            if (tag_len == LEN_W'(1)) begin
               eof_n     = 1'b1;
               win_cnt_n = win_cnt + 1'b1;
               state_n   = GAP;
            end else begin
               state_n = WIN;
            end
         end else begin
            case (state)
               WIN: begin
                  valid_n = 1'b1;
                  data_n  = in_data;
                  cnt_n   = cnt_inc;
                  if (cnt_inc == len_r) begin
                     eof_n     = 1'b1;
                     win_cnt_n = win_cnt + 1'b1;
                     state_n   = GAP;
                  end
               end
               GAP:     set_long = 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clock or posedge reset_int) begin
      if (reset_int) begin
         state     <= HUNT;
         cnt       <= '0;
         len_r     <= '0;
         win_cnt   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         len_r     <= len_n;
         win_cnt   <= win_cnt_n;
         out_valid <= valid_n;
         out_data  <= data_n;
         out_sof   <= sof_n;
         out_eof   <= eof_n;
         // A new error in the clearing cycle must not be lost.
         err_short <= set_short | (err_short & ~err_clr);
         err_long  <= set_long  | (err_long  & ~err_clr);
      end
   end

   assign busy = (state == WIN);

endmodule

// File: tb/tb_tag_decoder.sv
// Bench for tag_decoder: directed scenarios plus randomized traffic against a
// remaining-samples reference model. A narrow window counter exercises wrap.
module tb_tag_decoder;

   localparam int DW = 16;
   localparam int LW = 16;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset_int;
   logic          enable, in_valid, in_tag, err_clr;
   logic [LW-1:0] win_len;
   logic [DW-1:0] in_data;
   logic          out_valid, out_sof, out_eof, err_short, err_long, busy;
   logic [DW-1:0] out_data;
   logic [CW-1:0] win_cnt;

   int checks = 0;
   int errors = 0;

   // reference model state
   int            rem;       // samples still owed to the open window, 0 = none open
   bit            done;      // last window completed and no new window since
   logic          exp_valid, exp_sof, exp_eof, exp_short, exp_long;
   logic [DW-1:0] exp_data;
   logic [CW-1:0] exp_cnt;

   tag_decoder #(.DATA_W(DW), .LEN_W(LW), .CNT_W(CW)) dut (
      .clock(clock), .reset_int(reset_int), .enable(enable), .win_len(win_len),
      .in_valid(in_valid), .in_tag(in_tag), .in_data(in_data), .err_clr(err_clr),
      .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
      .win_cnt(win_cnt), .err_short(err_short), .err_long(err_long), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic model_reset();
      rem = 0; done = 0;
      exp_valid = 0; exp_sof = 0; exp_eof = 0; exp_short = 0; exp_long = 0;
      exp_data = '0; exp_cnt = '0;
   endtask

   // Drive one cycle of inputs, advance the model, and land #1 after the edge.
   task automatic step(input logic en, input logic v, input logic tag,
                       input logic [DW-1:0] d, input logic [LW-1:0] len, input logic clr);
      bit s_short, s_long;
      int l;
      @(negedge clock);
      enable = en; in_valid = v; in_tag = tag; in_data = d; win_len = len; err_clr = clr;
      s_short = 0; s_long = 0;
      exp_valid = 0; exp_sof = 0; exp_eof = 0;
      if (!en) begin
         rem = 0; done = 0;
      end else if (v) begin
         if (tag) begin
            if (rem > 0) s_short = 1;
            l = (len == 0) ? 1 : int'(len);
            exp_valid = 1; exp_sof = 1; exp_data = d;
            rem = l - 1; done = 0;
         end else if (rem > 0) begin
            exp_valid = 1; exp_data = d;
            rem = rem - 1;
         end else if (done) begin
            s_long = 1;
         end
         if (exp_valid && rem == 0) begin
            exp_eof = 1; exp_cnt = exp_cnt + 1'b1; done = 1;
         end
      end
      if (clr) begin exp_short = 0; exp_long = 0; end
      if (s_short) exp_short = 1;
      if (s_long)  exp_long = 1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_int = 1'b1;
      enable = 0; in_valid = 0; in_tag = 0; in_data = '0; win_len = '0; err_clr = 0;
      model_reset();
      repeat (2) @(posedge clock);
      #2 reset_int = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_data, out_sof, out_eof, win_cnt, err_short, err_long, busy} !== '0) begin
         errors++; $display("FAIL reset_outputs got %h required 0",
            {out_valid, out_data, out_sof, out_eof, win_cnt, err_short, err_long, busy});
      end
   endtask

   task automatic test_clean();
      logic [DW-1:0] w;
      for (int i = 0; i < 4; i++) begin
         w = DW'(16'h0101 + i);
         step(1, 1, i == 0, w, 4, 0);
         checks++;
         if ({out_valid, out_data, out_sof, out_eof} !== {1'b1, w, i == 0, i == 3}) begin
            errors++; $display("FAIL clean_word%0d got v%b d%h s%b e%b required d%h", i,
               out_valid, out_data, out_sof, out_eof, w);
         end
      end
      checks++;
      if ({win_cnt, err_short, err_long, busy} !== {4'd1, 3'b000}) begin
         errors++; $display("FAIL clean_status got cnt%0d s%b l%b b%b required cnt1 000",
            win_cnt, err_short, err_long, busy);
      end
   endtask

   task automatic test_hunt_drop();
      step(0, 0, 0, 0, 4, 0);
      step(1, 1, 0, 16'h00AA, 4, 0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL hunt_drop_aa got valid %b required 0", out_valid);
      end
      step(1, 1, 0, 16'h00BB, 4, 0);
      step(1, 1, 1, 16'h0101, 4, 0);
      checks++;
      if ({out_valid, out_data, out_sof, err_long} !== {1'b1, 16'h0101, 1'b1, 1'b0}) begin
         errors++; $display("FAIL hunt_first_word got v%b d%h s%b l%b required 1 0101 1 0",
            out_valid, out_data, out_sof, err_long);
      end
      for (int i = 1; i < 4; i++) step(1, 1, 0, DW'(16'h0101 + i), 4, 0);
      checks++;
      if ({out_eof, win_cnt} !== {1'b1, 4'd2}) begin
         errors++; $display("FAIL hunt_window_end got e%b cnt%0d required 1 2", out_eof, win_cnt);
      end
   endtask

   task automatic test_short();
      step(1, 1, 1, 16'h0001, 4, 0);
      step(1, 1, 0, 16'h0002, 4, 0);
      checks++;
      if ({out_data, out_eof} !== {16'h0002, 1'b0}) begin
         errors++; $display("FAIL short_no_eof got d%h e%b required 0002 0", out_data, out_eof);
      end
      step(1, 1, 1, 16'h0010, 4, 0);
      checks++;
      if ({out_valid, out_data, out_sof, err_short, win_cnt, busy} !==
          {1'b1, 16'h0010, 1'b1, 1'b1, 4'd2, 1'b1}) begin
         errors++; $display("FAIL short_restart got v%b d%h s%b es%b cnt%0d b%b required 1 0010 1 1 2 1",
            out_valid, out_data, out_sof, err_short, win_cnt, busy);
      end
      step(0, 0, 0, 0, 4, 1);
      checks++;
      if (err_short !== 1'b0) begin
         errors++; $display("FAIL short_clear got %b required 0", err_short);
      end
   endtask

   task automatic test_overrun_clear();
      step(1, 1, 1, 16'h0A00, 2, 0);
      step(1, 1, 0, 16'h0A01, 7, 0);
      checks++;
      if ({out_eof, busy} !== 2'b10) begin
         errors++; $display("FAIL overrun_window got e%b b%b required 1 0", out_eof, busy);
      end
      step(1, 1, 0, 16'h0F0F, 2, 0);
      checks++;
      if ({out_valid, err_long} !== 2'b01) begin
         errors++; $display("FAIL overrun_set got v%b l%b required 0 1", out_valid, err_long);
      end
      step(1, 1, 0, 16'h0F10, 2, 1);
      checks++;
      if (err_long !== 1'b1) begin
         errors++; $display("FAIL overrun_set_wins got %b required 1", err_long);
      end
      step(1, 0, 0, 0, 2, 1);
      checks++;
      if (err_long !== 1'b0) begin
         errors++; $display("FAIL overrun_clear got %b required 0", err_long);
      end
   endtask

   task automatic test_len0();
      logic [CW-1:0] base;
      base = win_cnt;
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 1, DW'(16'h0200 + i), 0, 0);
         checks++;
         if ({out_valid, out_sof, out_eof, win_cnt, busy} !==
             {3'b111, CW'(base + i + 1), 1'b0}) begin
            errors++; $display("FAIL len0_%0d got v%b s%b e%b cnt%0d b%b required 111 cnt%0d 0", i,
               out_valid, out_sof, out_eof, win_cnt, busy, CW'(base + i + 1));
         end
      end
   endtask

   task automatic test_enable_low();
      logic [CW-1:0] base;
      base = win_cnt;
      step(1, 1, 1, 16'h0301, 4, 0);
      step(1, 1, 0, 16'h0302, 4, 0);
      step(0, 1, 0, 16'h0303, 4, 0);
      checks++;
      if ({out_valid, out_eof, busy, win_cnt} !== {3'b000, base}) begin
         errors++; $display("FAIL enable_low got v%b e%b b%b cnt%0d required 000 cnt%0d",
            out_valid, out_eof, busy, win_cnt, base);
      end
      step(1, 1, 0, 16'h0304, 4, 0);
      checks++;
      if ({out_valid, err_long} !== 2'b00) begin
         errors++; $display("FAIL enable_low_hunt got v%b l%b required 00", out_valid, err_long);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 20 && win_cnt !== '1; i++) step(1, 1, 1, DW'(i), 1, 0);
      checks++;
      if (win_cnt !== '1) begin
         errors++; $display("FAIL wrap_preset got %0d required %0d", win_cnt, 4'hF);
      end
      step(1, 1, 1, 16'hFFFF, 1, 0);
      checks++;
      if ({win_cnt, out_eof} !== {4'd0, 1'b1}) begin
         errors++; $display("FAIL wrap_zero got cnt%0d e%b required 0 1", win_cnt, out_eof);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
              DW'($urandom), LW'($urandom_range(0, 5)), $urandom_range(0, 15) == 0);
         checks++;
         if ({out_valid, out_sof, out_eof, win_cnt, err_short, err_long, busy} !==
             {exp_valid, exp_sof, exp_eof, exp_cnt, exp_short, exp_long, rem > 0} ||
             (exp_valid && out_data !== exp_data)) begin
            errors++; $display("FAIL random_cycle%0d got v%b d%h s%b e%b c%0d es%b el%b b%b required v%b d%h s%b e%b c%0d es%b el%b b%b",
               i, out_valid, out_data, out_sof, out_eof, win_cnt, err_short, err_long, busy,
               exp_valid, exp_data, exp_sof, exp_eof, exp_cnt, exp_short, exp_long, rem > 0);
         end
      end
   endtask

   task automatic test_reset_mid_window();
      step(1, 1, 1, 16'h0501, 5, 0);
      step(1, 1, 0, 16'h0502, 5, 0);
      #2 reset_int = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_data, out_sof, out_eof, win_cnt, err_short, err_long, busy} !== '0) begin
         errors++; $display("FAIL reset_async got %h required 0",
            {out_valid, out_data, out_sof, out_eof, win_cnt, err_short, err_long, busy});
      end
      model_reset();
      @(negedge clock);
      reset_int = 1'b0;
      step(1, 1, 0, 16'h0503, 5, 0);
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
         errors++; $display("FAIL reset_hunt got v%b b%b required 00", out_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_hunt_drop();
      test_short();
      test_overrun_clear();
      test_len0();
      test_enable_low();
      test_wrap();
      test_random();
      test_reset_mid_window();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
